// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - quadrature decoder signal bundle
interface quad_decoder_if #(
  parameter int WIDTH = 8
);
  logic             a_in;
  logic             b_in;
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic             clr_err;
  logic             step;
  logic             dir;
  logic [WIDTH-1:0] position;
  logic             err;

  modport master (
    output a_in, b_in, load, d_in, clr_err,
    input  step, dir, position, err
  );

  modport slave (
    input  a_in, b_in, load, d_in, clr_err,
    output step, dir, position, err
  );
endinterface

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - glitch-filtered quadrature decoder with position counter
module quad_decoder #(
  parameter int WIDTH = 8,
  parameter int FILT  = 2
) (
  input logic          clk,
  input logic          rst_n,
  quad_decoder_if.slave bus
);
  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int IW = $clog2(FILT + 4);

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  // Pair bit 1 is channel A, bit 0 is channel B.
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       filt;
  logic [1:0]       filt_q;
  logic [CW-1:0]    cnt [2];
  logic [1:0]       state;
  logic             init;
  logic [IW-1:0]    init_cnt;
  logic             step_r;
  logic             dir_r;
  logic             err_r;
  logic [WIDTH-1:0] pos_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 2'b00;
      sync2  <= 2'b00;
      filt   <= 2'b00;
      filt_q <= 2'b00;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1  <= {bus.a_in, bus.b_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (cnt[i] == CW'(FILT - 1)) begin
            filt[i] <= sync2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Gray position of a pair: forward sequence maps to 0,1,2,3.
  function automatic logic [1:0] gray_idx(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  logic [1:0] delta;
  logic       change;
  logic       fwd;
  logic       valid;
  logic       illegal;

  always_comb begin
    delta   = gray_idx(filt_q) - gray_idx(state);
    change  = (filt_q != state);
    fwd     = (delta == 2'd1);
    valid   = change && !init && (delta == 2'd1 || delta == 2'd3);
    illegal = change && !init && (delta == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S00;
      init     <= 1'b1;
      init_cnt <= '0;
      step_r   <= 1'b0;
      dir_r    <= 1'b1;
      err_r    <= 1'b0;
      pos_r    <= '0;
    end else begin
      step_r <= valid;
      if (valid) begin
        dir_r <= fwd;
      end
      if (bus.load) begin
        pos_r <= bus.d_in;
      end else if (valid) begin
        pos_r <= fwd ? pos_r + WIDTH'(1) : pos_r - WIDTH'(1);
      end
      if (illegal) begin
        err_r <= 1'b1;
      end else if (bus.clr_err) begin
        err_r <= 1'b0;
      end
      if (change) begin
        state <= filt_q;
      end
      // Timeout only counts cycles with nothing pending in the filter pipeline.
      if (init) begin
        if (change) begin
          init <= 1'b0;
        end else if (filt == state) begin
          if (init_cnt == IW'(FILT + 2)) begin
            init <= 1'b0;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end
      end
    end
  end

  assign bus.step     = step_r;
  assign bus.dir      = dir_r;
  assign bus.err      = err_r;
  assign bus.position = pos_r;
endmodule
